mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data port of the unified instruction/data memory between two requesters: m0 = CPU load/store unit, m1 = I2C screen frame-fetch engine.
- Round-robin arbitration; one outstanding memory transaction at a time.
- Converts the memory's multi-cycle ren/ready read protocol into a simple req/ack handshake per master.
- Adds a read timeout with an error flag.
- Sits between both masters and the memory data port. The instruction port is untouched.

Parameters:
- ADDR_W, `DATA_BITS-2: word address width, matching the memory data_addr.
- TIMEOUT, 63: maximum WAIT cycles before a read is aborted. Range 8..255.
- ERR_DATA, 32'hDEADBEEF: rdata returned on a timed-out read.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- m0_req, m1_req  in  1  request; held high until the matching ack.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_addr, m1_addr  in  ADDR_W  word address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_be, m1_be  in  4  byte enables (bit3 = [31:24]).
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m0_err, m1_err  out  1  pulses with ack when a read timed out.
- m0_rdata, m1_rdata  out  32  read data; valid with ack, held until that master's next read completes.
- mem_addr  out  ADDR_W  to memory data_addr.
- mem_ren, mem_wen  out  1  to memory ren/wen; never both high.
- mem_wdata  out  32  to memory data_in.
- mem_be  out  4  to memory byte_select_vector.
- mem_rdata  in  32  from memory data_out.
- mem_ready  in  1  from memory ready.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=DRAIN; all outputs 0; rr_last=1, so m0 wins the first tie.
  - All rdata registers are cleared to 0.
- DRAIN: wait until mem_ready=1, which protects against a read the memory was executing before reset, then go to IDLE. No memory strobes are driven.
- IDLE:
  - If any req is high, select a winner. A lone requester wins. If both are high, the master not equal to rr_last wins.
  - Latch the winner's addr/wdata/be/we and the grant index; update rr_last; go to ISSUE.
  - Requests arriving while not in IDLE wait.
- ISSUE (exactly 1 cycle):
  - Drive mem_addr/mem_wdata/mem_be from the latches.
  - Raise mem_wen if we=1, otherwise mem_ren.
  - Next state is RESP for a write, WAIT for a read; clear the timeout counter.
  - The strobe must drop after this cycle; a held ren re-issues the read.
- WAIT:
  - Strobes low; address still driven.
  - If mem_ready=1, capture mem_rdata into the granted master's rdata and go to RESP.
  - The first WAIT cycle sees ready=0 for an in-range read. An out-of-range read sees ready=1 immediately with data 0 and completes normally.
  - Otherwise increment the counter. When counter==TIMEOUT, load ERR_DATA, set the err flag and go to RESP.
- RESP (1 cycle): pulse the granted master's ack, and err if flagged; clear the flag; go to IDLE.
  - A master may drop req in the cycle after ack.
  - A re-asserted req is eligible in the following IDLE cycle.
- Latency with the current memory model:
  - Write: ack 2 cycles after IDLE sampling.
  - Read: ISSUE, then 8 WAIT cycles, then RESP, so ack is 10 cycles after IDLE sampling.
- Both masters are continuously requesting: grants strictly alternate m0, m1, m0, ...
- A requester dropping req mid-transaction: the transaction still completes, and ack is still pulsed and may be ignored.
- Reset mid-WAIT: the state machine enters DRAIN and no ack is produced.

Decomposition:
- Shared package: state encodings (DRAIN, IDLE, ISSUE, WAIT, RESP as 3-bit), master index constants M0=0/M1=1, ERR_DATA default.
- One sub-module, rr_arb2: the combinational two-way round-robin winner select from req[1:0] and rr_last. Everything else lives in the top-level module.

Test Plan:
- m0 read of addr 5, memory word 32'h12345678 → mem_ren high for exactly 1 cycle; m0_ack 10 cycles after req sampled; m0_rdata=32'h12345678; m0_err=0.
- m1 write addr 9, wdata 32'hAABBCCDD, be 4'b0101 → single-cycle mem_wen; memory word becomes xxBBxxDD; m1_ack 2 cycles after sampling.
- Both req held continuously for 6 reads → grant order m0,m1,m0,m1,m0,m1; no cycle with mem_ren and mem_wen both high.
- Read of addr ≥ memory depth → ready never drops; ack 3 cycles after sampling with rdata=0.
- Stub memory holding mem_ready=0 → m0_ack and m0_err together after TIMEOUT+1 WAIT cycles; rdata=32'hDEADBEEF.
- Assert reset in the 3rd WAIT cycle, release → no ack; DRAIN held until mem_ready=1; the next request is served normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory data-port arbiter: FSM encoding,
// master indices and the word returned on a timed-out read.
package mem_port_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_DRAIN = 3'd0,
      ST_IDLE  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_RESP  = 3'd4
   } state_e;

   localparam logic        M0           = 1'b0;
   localparam logic        M1           = 1'b1;
   localparam int          ADDR_W_DEF   = 14;
   localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

   // One-hot per-master strobe from a master index.
   function automatic logic [1:0] idx2oh(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin winner select: a lone requester wins, a tie goes to
// the master that was not granted last.
module rr_arb2
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       rr_last_i,
   output logic       gnt_vld_o,
   output logic       gnt_idx_o
);

   // Winner decode from the request pair and the last grant.
   always_comb begin
      gnt_vld_o = |req_i;
      case (req_i)
         2'b01:   gnt_idx_o = M0;
         2'b10:   gnt_idx_o = M1;
         2'b11:   gnt_idx_o = (rr_last_i == M0) ? M1 : M0;
         default: gnt_idx_o = M0;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the memory data port between the CPU load/store unit (m0) and the
// screen frame-fetch engine (m1); one transaction at a time, read timeout.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int          ADDR_W   = ADDR_W_DEF,
   parameter int          TIMEOUT  = 63,
   parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [31:0]       m0_wdata,
   input  logic [3:0]        m0_be,
   output logic              m0_ack,
   output logic              m0_err,
   output logic [31:0]       m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [31:0]       m1_wdata,
   input  logic [3:0]        m1_be,
   output logic              m1_ack,
   output logic              m1_err,
   output logic [31:0]       m1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_ren,
   output logic              mem_wen,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic              busy
);

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   state_e            state_q;
   logic              rr_last_q;
   logic              gnt_q;
   logic              we_q;
   logic [7:0]        cnt_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wdata_q;
   logic [3:0]        mem_be_q;
   logic              mem_ren_q;
   logic              mem_wen_q;
   logic [1:0]        ack_q;
   logic [1:0]        err_q;
   logic [31:0]       rdata0_q;
   logic [31:0]       rdata1_q;
   logic              busy_q;

   logic              gnt_vld_s;
   logic              gnt_idx_s;
   logic              sel_we_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [31:0]       sel_wdata_s;
   logic [3:0]        sel_be_s;

   rr_arb2 u_rr_arb2 (
      .req_i     ({m1_req, m0_req}),
      .rr_last_i (rr_last_q),
      .gnt_vld_o (gnt_vld_s),
      .gnt_idx_o (gnt_idx_s)
   );

   assign sel_we_s    = (gnt_idx_s == M1) ? m1_we    : m0_we;
   assign sel_addr_s  = (gnt_idx_s == M1) ? m1_addr  : m0_addr;
   assign sel_wdata_s = (gnt_idx_s == M1) ? m1_wdata : m0_wdata;
   assign sel_be_s    = (gnt_idx_s == M1) ? m1_be    : m0_be;

   // Transaction FSM; strobes, acks, errors and read data are all registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_DRAIN;
         rr_last_q   <= M1;
         gnt_q       <= M0;
         we_q        <= 1'b0;
         cnt_q       <= 8'd0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'd0;
         mem_be_q    <= 4'd0;
         mem_ren_q   <= 1'b0;
         mem_wen_q   <= 1'b0;
         ack_q       <= 2'b00;
         err_q       <= 2'b00;
         rdata0_q    <= 32'd0;
         rdata1_q    <= 32'd0;
         busy_q      <= 1'b0;
      end else begin
         // Strobes and completion flags are single-cycle pulses.
         mem_ren_q <= 1'b0;
         mem_wen_q <= 1'b0;
         ack_q     <= 2'b00;
         err_q     <= 2'b00;
         case (state_q)
            ST_DRAIN: begin
               if (mem_ready) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  busy_q  <= 1'b1;
               end
            end
            ST_IDLE: begin
               if (gnt_vld_s) begin
                  gnt_q       <= gnt_idx_s;
                  rr_last_q   <= gnt_idx_s;
                  we_q        <= sel_we_s;
                  mem_addr_q  <= sel_addr_s;
                  mem_wdata_q <= sel_wdata_s;
                  mem_be_q    <= sel_be_s;
                  mem_wen_q   <= sel_we_s;
                  mem_ren_q   <= ~sel_we_s;
                  busy_q      <= 1'b1;
                  state_q     <= ST_ISSUE;
               end else begin
                  busy_q      <= 1'b0;
               end
            end
            ST_ISSUE: begin
               cnt_q <= 8'd0;
               if (we_q) begin
                  ack_q   <= idx2oh(gnt_q);
                  state_q <= ST_RESP;
               end else begin
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_ready || (cnt_q == TMO)) begin
                  if (gnt_q == M1) begin
                     rdata1_q <= mem_ready ? mem_rdata : ERR_DATA;
                  end else begin
                     rdata0_q <= mem_ready ? mem_rdata : ERR_DATA;
                  end
                  ack_q   <= idx2oh(gnt_q);
                  err_q   <= mem_ready ? 2'b00 : idx2oh(gnt_q);
                  state_q <= ST_RESP;
               end else begin
                  cnt_q   <= cnt_q + 8'd1;
               end
            end
            ST_RESP: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b1;
               state_q <= ST_DRAIN;
            end
         endcase
      end
   end

   assign m0_ack    = ack_q[0];
   assign m1_ack    = ack_q[1];
   assign m0_err    = err_q[0];
   assign m1_err    = err_q[1];
   assign m0_rdata  = rdata0_q;
   assign m1_rdata  = rdata1_q;
   assign mem_addr  = mem_addr_q;
   assign mem_ren   = mem_ren_q;
   assign mem_wen   = mem_wen_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: behavioural multi-cycle memory, a transaction-level
// reference (arbitration rule, latency, shadow memory) and random masters.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int          ADDR_W   = 10;
   localparam int          TMO      = 40;
   localparam int          DEPTH    = 256;
   localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic [1:0]             req_s   = '0;
   logic [1:0]             we_s    = '0;
   logic [1:0][ADDR_W-1:0] addr_s  = '0;
   logic [1:0][31:0]       wdata_s = '0;
   logic [1:0][3:0]        be_s    = '0;
   logic [1:0]             ack_s, err_s;
   logic [1:0][31:0]       rdata_s;
   logic [ADDR_W-1:0]      mem_addr;
   logic                   mem_ren, mem_wen, mem_ready, busy;
   logic [31:0]            mem_wdata, mem_rdata;
   logic [3:0]             mem_be;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TMO), .ERR_DATA(ERR_WORD)) dut (
      .clk(clk), .reset(reset),
      .m0_req(req_s[0]), .m0_we(we_s[0]), .m0_addr(addr_s[0]), .m0_wdata(wdata_s[0]),
      .m0_be(be_s[0]), .m0_ack(ack_s[0]), .m0_err(err_s[0]), .m0_rdata(rdata_s[0]),
      .m1_req(req_s[1]), .m1_we(we_s[1]), .m1_addr(addr_s[1]), .m1_wdata(wdata_s[1]),
      .m1_be(be_s[1]), .m1_ack(ack_s[1]), .m1_err(err_s[1]), .m1_rdata(rdata_s[1]),
      .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] m;
      m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (old & ~m) | (nw & m);
   endfunction

   // Memory: ready drops after a read strobe, returns 7 cycles later with data.
   logic [31:0] mem [DEPTH];
   logic        rdy_r   = 1'b1;
   logic [31:0] dout_r  = 32'd0;
   logic [2:0]  cnt_r   = 3'd0;
   logic [7:0]  lat_r   = 8'd0;
   logic        stall   = 1'b0;
   logic        ld_en   = 1'b0;
   logic [7:0]  ld_addr = 8'd0;
   logic [31:0] ld_data = 32'd0;

   always @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      else if (mem_wen && mem_addr < ADDR_W'(DEPTH))
         mem[mem_addr[7:0]] <= merge(mem[mem_addr[7:0]], mem_wdata, mem_be);
      if (mem_ren) begin
         if (mem_addr < ADDR_W'(DEPTH)) begin
            rdy_r <= 1'b0; cnt_r <= 3'd6; lat_r <= mem_addr[7:0];
         end else begin
            rdy_r <= 1'b1; dout_r <= 32'd0;
         end
      end else if (!rdy_r) begin
         if (cnt_r == 3'd0) begin
            rdy_r <= 1'b1; dout_r <= mem[lat_r];
         end else begin
            cnt_r <= cnt_r - 3'd1;
         end
      end
   end
   assign mem_ready = rdy_r & ~stall;
   assign mem_rdata = dout_r;

   // Reference: expected winner, strobe contents, ack cycle, err and rdata.
   logic [31:0]            ref_mem [DEPTH];
   logic [1:0]             pend = '0, pend_we = '0, pend_err = '0;
   logic [1:0][ADDR_W-1:0] pend_addr = '0;
   logic [1:0][31:0]       pend_wdata = '0, rd_hold = '0;
   logic [1:0][3:0]        pend_be = '0;
   int                     exp_cyc [2];
   logic                   rr_m = 1'b1, prev_strobe = 1'b0;
   logic [1:0]             mon_rq;
   int                     mon_w;
   int                     grants [$];

   always begin
      @(posedge clk); #1;
      if (!reset) begin
         pend = '0; rr_m = 1'b1; prev_strobe = 1'b0;
      end else begin
         check_eq("ren_wen_excl", 32'(mem_ren & mem_wen), 32'd0);
         if (mem_ren || mem_wen) begin
            check_eq("strobe_once", 32'(prev_strobe), 32'd0);
            mon_rq = req_s;
            check_eq("grant_has_req", 32'(mon_rq != 2'b00), 32'd1);
            if (mon_rq == 2'b11) mon_w = rr_m ? 0 : 1;
            else mon_w = mon_rq[1] ? 1 : 0;
            rr_m = (mon_w == 1);
            check_eq("grant_addr", 32'(mem_addr), 32'(addr_s[mon_w]));
            check_eq("grant_dir", 32'({mem_wen, mem_ren}), 32'({we_s[mon_w], ~we_s[mon_w]}));
            if (we_s[mon_w]) begin
               check_eq("grant_wdata", mem_wdata, wdata_s[mon_w]);
               check_eq("grant_be", 32'(mem_be), 32'(be_s[mon_w]));
            end
            pend[mon_w]       = 1'b1;
            pend_we[mon_w]    = we_s[mon_w];
            pend_addr[mon_w]  = addr_s[mon_w];
            pend_wdata[mon_w] = wdata_s[mon_w];
            pend_be[mon_w]    = be_s[mon_w];
            pend_err[mon_w]   = !we_s[mon_w] && stall;
            exp_cyc[mon_w] = cyc + (we_s[mon_w] ? 1 : stall ? TMO + 2 :
                                    (addr_s[mon_w] >= ADDR_W'(DEPTH)) ? 2 : 9);
            grants.push_back(mon_w);
         end
         prev_strobe = mem_ren | mem_wen;
         for (int m = 0; m < 2; m++) begin
            if (ack_s[m]) begin
               check_eq("ack_expected", 32'(pend[m]), 32'd1);
               check_eq("ack_cycle", cyc, exp_cyc[m]);
               check_eq("err_flag", 32'(err_s[m]), 32'(pend_err[m]));
               if (pend_we[m]) begin
                  if (pend_addr[m] < ADDR_W'(DEPTH))
                     ref_mem[pend_addr[m][7:0]] = merge(ref_mem[pend_addr[m][7:0]],
                                                        pend_wdata[m], pend_be[m]);
               end else begin
                  rd_hold[m] = pend_err[m] ? ERR_WORD :
                               (pend_addr[m] >= ADDR_W'(DEPTH)) ? 32'd0 : ref_mem[pend_addr[m][7:0]];
               end
               check_eq("rdata", rdata_s[m], rd_hold[m]);
               pend[m] = 1'b0;
            end else if (err_s[m]) begin
               check_eq("err_without_ack", 32'(err_s[m]), 32'd0);
            end
         end
      end
   end

   task automatic do_txn(input int m, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [31:0] d, input logic [3:0] b,
                         output logic [31:0] rd, output logic er);
      logic got;
      @(negedge clk);
      we_s[m] = w; addr_s[m] = a; wdata_s[m] = d; be_s[m] = b; req_s[m] = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         got = ack_s[m];
      end
      check_eq("ack_arrives", 32'(got), 32'd1);
      rd = rdata_s[m];
      er = err_s[m];
      req_s[m] = 1'b0;
   endtask

   task automatic rand_master(input int m, input int n, input int max_gap, input int max_addr);
      logic [31:0]       rd;
      logic              er;
      logic              w;
      logic [ADDR_W-1:0] a;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, max_gap)) @(negedge clk);
         w = (max_addr > 15) ? 1'b0 : ($urandom_range(0, 2) == 0);
         a = ($urandom_range(0, 7) == 0 && max_addr <= 15) ? ADDR_W'(DEPTH + $urandom_range(0, 15))
                                                           : ADDR_W'($urandom_range(0, max_addr));
         do_txn(m, w, a, $urandom, 4'($urandom_range(0, 15)), rd, er);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   logic [31:0] rd;
   logic        er;
   int          n_drain;
   logic        seen;

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         ld_en = 1'b1; ld_addr = 8'(i);
         ld_data = (i == 5) ? 32'h12345678 : (i == 9) ? 32'h11223344 : $urandom;
         ref_mem[i] = ld_data;
      end
      @(negedge clk);
      ld_en = 1'b0;
      check_eq("rst_ack", 32'(ack_s), 32'd0);
      check_eq("rst_err", 32'(err_s), 32'd0);
      check_eq("rst_rdata0", rdata_s[0], 32'd0);
      check_eq("rst_rdata1", rdata_s[1], 32'd0);
      check_eq("rst_strobes", 32'({mem_ren, mem_wen}), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_addr", 32'(mem_addr), 32'd0);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      do_txn(0, 1'b0, ADDR_W'(5), 32'd0, 4'hF, rd, er);
      check_eq("t1_rdata", rd, 32'h12345678);
      check_eq("t1_err", 32'(er), 32'd0);

      do_txn(1, 1'b1, ADDR_W'(9), 32'hAABBCCDD, 4'b0101, rd, er);
      @(negedge clk);
      check_eq("t2_memword", mem[9], 32'h11BB33DD);

      grants.delete();
      fork
         rand_master(0, 3, 0, 200);
         rand_master(1, 3, 0, 200);
      join
      check_eq("t3_ngrants", grants.size(), 32'd6);
      for (int i = 0; i < 6 && i < grants.size(); i++)
         check_eq("t3_alternate", grants[i], i % 2);

      do_txn(0, 1'b0, ADDR_W'(300), 32'd0, 4'hF, rd, er);
      check_eq("t4_oor_rdata", rd, 32'd0);
      check_eq("t4_oor_err", 32'(er), 32'd0);

      stall = 1'b1;
      do_txn(0, 1'b0, ADDR_W'(7), 32'd0, 4'hF, rd, er);
      stall = 1'b0;
      check_eq("t5_tmo_err", 32'(er), 32'd1);
      check_eq("t5_tmo_rdata", rd, ERR_WORD);

      // Reset during the third WAIT cycle of an m1 read.
      @(negedge clk);
      we_s[1] = 1'b0; addr_s[1] = ADDR_W'(3); req_s[1] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = mem_ren;
      end
      check_eq("t6_issue_seen", 32'(seen), 32'd1);
      repeat (3) @(negedge clk);
      reset = 1'b0; req_s[1] = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      we_s[0] = 1'b0; addr_s[0] = ADDR_W'(5); req_s[0] = 1'b1;
      n_drain = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_ready) break;
         n_drain++;
         check_eq("t6_drain_busy", 32'(busy), 32'd1);
         check_eq("t6_drain_quiet", 32'({mem_ren, mem_wen, ack_s}), 32'd0);
      end
      check_eq("t6_drain_held", 32'(n_drain > 0), 32'd1);
      req_s[0] = 1'b0;
      do_txn(0, 1'b0, ADDR_W'(5), 32'd0, 4'hF, rd, er);
      check_eq("t6_after_rdata", rd, 32'h12345678);

      fork
         rand_master(0, 30, 3, 15);
         rand_master(1, 30, 3, 15);
      join
      repeat (4) @(negedge clk);
      check_eq("end_no_pending", 32'(pend), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
